line_xfer_arb: RTL and testbench
================================

LINE_XFER_ARB -- requirements
Module: line_xfer_arb

Interface
REQ-001 Parameter PA, default 22, physical address width in bits.
REQ-002 Parameter LINE_LENGTH, default 4, cache line bytes; beats per line NB = 2*LINE_LENGTH nibbles.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 d_push, d_pull  input  1 each  dcache requests a line write-back / line fill.
REQ-006 d_tag  input  PA-log2(LINE_LENGTH)  dcache line address.
REQ-007 d_dwrite  input  4  dcache outgoing nibble; d_dread  output  4  nibble into dcache.
REQ-008 d_wstrobe, d_rstrobe  output  1 each  dcache nibble accepted-in / taken-out strobes.
REQ-009 i_pull  input  1  icache line fill request; i_tag  input  PA-log2(LINE_LENGTH)  icache line address.
REQ-010 i_dread  output  4  nibble into icache; i_wstrobe  output  1  icache nibble strobe.
REQ-011 mem_req  output  1; mem_we  output  1; mem_addr  output  PA-log2(LINE_LENGTH)  memory command.
REQ-012 mem_ack  input  1  command accepted; mem_wdata  output  4; mem_wready  input  1.
REQ-013 mem_rdata  input  4; mem_rvalid  input  1  read beat valid.
REQ-014 busy  output  1  FSM not IDLE.

Function
REQ-015 FSM states IDLE, ADDR, DATA, DONE.
REQ-016 IDLE: any request (d_push|d_pull|i_pull) -> ADDR next edge; grant owner, direction (write iff d_push granted) and tag latched at that edge.
REQ-017 dcache: d_push beats d_pull when both high.
REQ-018 ADDR: mem_req=1, mem_we/mem_addr from latched values, held stable until mem_ack; mem_ack -> DATA, beat counter cleared to 0.
REQ-019 DATA read: each mem_rvalid cycle = one beat; owner's wstrobe=mem_rvalid and dread=mem_rdata, combinational, same cycle; other requester's strobe 0.
REQ-020 DATA write: mem_wdata=d_dwrite combinational; d_rstrobe=mem_wready; each mem_wready cycle = one beat.
REQ-021 Beat counter width log2(NB); beat NB-1 -> DONE, no wrap into further beats; mem_rvalid/mem_wready ignored outside DATA.
REQ-022 DONE: exactly one cycle, all strobes 0, then IDLE; gap lets requester drop/update its request; no new grant in DONE.
REQ-023 Minimum transfer: 1 (IDLE) + 1 (ADDR, ack same cycle) + NB + 1 (DONE) cycles.
REQ-024 Requests dropped after grant ignored; transfer always completes all NB beats.
REQ-025 Latched tag/owner/direction unchanged ADDR through DONE regardless of input changes.
REQ-026 d_dread and i_dread = mem_rdata always; only strobes qualify them.

Reset
REQ-027 reset (incl. mid-transfer) -> IDLE, counter 0, mem_req=0, mem_we=0, all strobes 0, busy=0, round-robin pointer = dcache first.
REQ-028 Transfer aborted by reset not resumed; requester re-requests.

Configuration
REQ-029 Macro LINE_XFER_RR_EN defined: dcache/icache contention granted round-robin; pointer moves to the other requester after each completed grant.
REQ-030 LINE_XFER_RR_EN undefined: fixed priority, dcache always wins contention; no pointer state.

Verification
REQ-031 i_pull=1, i_tag=0x1234, mem_ack 1st ADDR cycle, mem_rvalid 8 cycles rdata 0..7 -> mem_we=0, mem_addr=0x1234, 8 i_wstrobe pulses i_dread 0..7, busy low after 11 cycles.
REQ-032 d_push=1, d_tag=0x0040, mem_wready toggled 1/0 -> mem_we=1, 8 d_rstrobe exactly on mem_wready cycles, mem_wdata tracks d_dwrite.
REQ-033 d_push,d_pull,i_pull all high from reset, RR_EN defined -> grants: d write, i read, d (push/pull as then presented), alternating.
REQ-034 Same stimulus RR_EN undefined -> icache starved while any dcache request held.
REQ-035 reset at beat 4 of read -> next cycle IDLE, strobes 0; re-request restarts at beat 0.
REQ-036 mem_ack delayed 5 cycles, tag input changed meanwhile -> mem_addr stays latched value.

Source files
------------

// File: rtl/line_xfer_arb.sv
// rtl/line_xfer_arb.sv - dcache/icache line transfer arbiter onto a nibble-wide memory port (option: LINE_XFER_RR_EN)
module line_xfer_arb #(
  parameter  int PA          = 22,
  parameter  int LINE_LENGTH = 4,
  localparam int TW          = PA - $clog2(LINE_LENGTH),
  localparam int NB          = 2 * LINE_LENGTH,
  localparam int CW          = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          reset,
  // dcache side
  input  logic          d_push,
  input  logic          d_pull,
  input  logic [TW-1:0] d_tag,
  input  logic [3:0]    d_dwrite,
  output logic [3:0]    d_dread,
  output logic          d_wstrobe,
  output logic          d_rstrobe,
  // icache side
  input  logic          i_pull,
  input  logic [TW-1:0] i_tag,
  output logic [3:0]    i_dread,
  output logic          i_wstrobe,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [TW-1:0] mem_addr,
  input  logic          mem_ack,
  output logic [3:0]    mem_wdata,
  input  logic          mem_wready,
  input  logic [3:0]    mem_rdata,
  input  logic          mem_rvalid,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Owner encoding: 0 = dcache, 1 = icache.
  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [TW-1:0] tag_q, tag_d;

  logic d_req;
  logic grant_i;
  logic beat;

`ifdef LINE_XFER_RR_EN
  // Points at the requester that wins the next dcache/icache contention.
  logic rr_ptr_q, rr_ptr_d;
`endif

  assign d_req = d_push | d_pull;

`ifdef LINE_XFER_RR_EN
  // Contention resolved by the round-robin pointer; a lone requester always wins.
  assign grant_i = i_pull & (~d_req | (rr_ptr_q == OWN_I));
`else
  // dcache wins every contention.
  assign grant_i = i_pull & ~d_req;
`endif

  // A beat is a handshake cycle in the direction of the current transfer.
  assign beat = (state_q == ST_DATA) & (we_q ? mem_wready : mem_rvalid);

  // State, beat counter and latched grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_D;
      we_q    <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      tag_q   <= tag_d;
    end
  end

`ifdef LINE_XFER_RR_EN
  // Round-robin pointer register, dcache first out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= OWN_D;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Next-state logic; grant fields are only captured when leaving IDLE so that
  // requester changes during a transfer cannot disturb it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    tag_d   = tag_q;
`ifdef LINE_XFER_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (d_req | i_pull) begin
          state_d = ST_ADDR;
          owner_d = grant_i ? OWN_I : OWN_D;
          we_d    = ~grant_i & d_push;
          tag_d   = grant_i ? i_tag : d_tag;
        end
      end
      ST_ADDR: begin
        if (mem_ack) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (beat) begin
          if (cnt_q == CW'(NB - 1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // One idle cycle so the requester can drop or change its request.
        state_d = ST_IDLE;
`ifdef LINE_XFER_RR_EN
        rr_ptr_d = ~owner_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command outputs come straight from the latched grant.
  assign mem_req  = (state_q == ST_ADDR);
  assign mem_we   = (state_q == ST_ADDR) & we_q;
  assign mem_addr = tag_q;

  // Data paths are unconditional; only the strobes qualify them.
  assign d_dread   = mem_rdata;
  assign i_dread   = mem_rdata;
  assign mem_wdata = d_dwrite;

  assign d_wstrobe = (state_q == ST_DATA) & ~we_q & (owner_q == OWN_D) & mem_rvalid;
  assign i_wstrobe = (state_q == ST_DATA) & ~we_q & (owner_q == OWN_I) & mem_rvalid;
  assign d_rstrobe = (state_q == ST_DATA) &  we_q & mem_wready;

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_line_xfer_arb.sv
// tb/tb_line_xfer_arb.sv - scoreboard bench for line_xfer_arb
module tb_line_xfer_arb;

  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_push, d_pull, i_pull;
  logic [TW-1:0] d_tag, i_tag, mem_addr;
  logic [3:0]    d_dwrite, d_dread, i_dread, mem_wdata, mem_rdata;
  logic          d_wstrobe, d_rstrobe, i_wstrobe;
  logic          mem_req, mem_we, mem_ack, mem_wready, mem_rvalid, busy;

  // kind: 0 command, 1 icache read beat, 2 dcache read beat, 3 dcache write beat
  typedef struct {
    int          kind;
    logic [23:0] val;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  line_xfer_arb dut (
    .clk        (clk),
    .reset      (reset),
    .d_push     (d_push),
    .d_pull     (d_pull),
    .d_tag      (d_tag),
    .d_dwrite   (d_dwrite),
    .d_dread    (d_dread),
    .d_wstrobe  (d_wstrobe),
    .d_rstrobe  (d_rstrobe),
    .i_pull     (i_pull),
    .i_tag      (i_tag),
    .i_dread    (i_dread),
    .i_wstrobe  (i_wstrobe),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .busy       (busy)
  );

  function automatic logic [23:0] cmd_val(input logic we, input logic [TW-1:0] tag);
    return {3'b000, we, tag};
  endfunction

  task automatic expect_ev(input int k, input logic [23:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic mon_ev(input int k, input logic [23:0] v);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%h, required no event", k, v);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val !== v) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%h, required kind=%0d val=%h", k, v, e.kind, e.val);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic chk_empty(input string nm);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d_push = 0; d_pull = 0; i_pull = 0;
    mem_ack = 0; mem_rvalid = 0; mem_wready = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Serves one transfer starting from an IDLE cycle with requests already driven;
  // rvalid and wready are both high on beat cycles so the wrong direction would show.
  task automatic run_xfer(input logic we, input int kind, input logic [TW-1:0] tag);
    expect_ev(0, cmd_val(we, tag));
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mem_rvalid = 1'b1;
      mem_wready = 1'b1;
      mem_rdata  = 4'(b);
      d_dwrite   = ~4'(b);
      if (we) expect_ev(3, {20'h0, ~4'(b)});
      else    expect_ev(kind, {20'h0, 4'(b)});
      tick();
    end
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    tick();
  endtask

  // Monitor: every DUT handshake pops one scoreboard entry.
  always @(negedge clk) begin
    if (mem_req && mem_ack) mon_ev(0, cmd_val(mem_we, mem_addr));
    if (i_wstrobe)          mon_ev(1, {20'h0, i_dread});
    if (d_wstrobe)          mon_ev(2, {20'h0, d_dread});
    if (d_rstrobe)          mon_ev(3, {20'h0, mem_wdata});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    d_tag = '0; i_tag = '0; d_dwrite = '0; mem_rdata = '0;
    do_reset();

    // Reset state; data handshakes in IDLE must raise no strobe.
    mem_rvalid = 1'b1;
    mem_wready = 1'b1;
    @(negedge clk);
    chk("reset_busy", {23'h0, busy}, 24'h0);
    chk("reset_mem_req", {23'h0, mem_req}, 24'h0);
    chk("reset_mem_we", {23'h0, mem_we}, 24'h0);
    tick();
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;

    // icache read, minimum latency, request dropped after grant.
    i_pull = 1'b1;
    i_tag  = 20'h01234;
    expect_ev(0, cmd_val(1'b0, 20'h01234));
    tick();
    i_pull  = 1'b0;
    i_tag   = 20'h00FFF;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 9; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 4'(b);
      if (b < 8) expect_ev(1, {20'h0, 4'(b)});
      if (b == 8) begin
        @(negedge clk);
        chk("done_busy", {23'h0, busy}, 24'h1);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("read_busy_after_11", {23'h0, busy}, 24'h0);
    chk_empty("read_events");
    tick();

    // dcache write-back with wready toggling.
    d_push = 1'b1;
    d_tag  = 20'h00040;
    expect_ev(0, cmd_val(1'b1, 20'h00040));
    tick();
    d_push  = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      mem_wready = (k % 2 == 0);
      d_dwrite   = 4'(k + 3);
      if (mem_wready) expect_ev(3, {20'h0, 4'(k + 3)});
      if (k == 5) begin
        @(negedge clk);
        chk("wdata_tracks", {20'h0, mem_wdata}, 24'h8);
      end
      tick();
    end
    mem_wready = 1'b0;
    @(negedge clk);
    chk("write_busy_end", {23'h0, busy}, 24'h0);
    chk_empty("write_events");
    tick();

    // Delayed ack with a changing tag input.
    d_pull = 1'b1;
    d_tag  = 20'h00ABC;
    expect_ev(0, cmd_val(1'b0, 20'h00ABC));
    tick();
    d_pull = 1'b0;
    d_tag  = 20'h05555;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      chk("held_mem_addr", {4'h0, mem_addr}, 24'h000ABC);
      chk("held_mem_req", {23'h0, mem_req}, 24'h1);
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 4'(15 - b);
      expect_ev(2, {20'h0, 4'(15 - b)});
      tick();
    end
    mem_rvalid = 1'b0;
    tick();
    chk_empty("delayed_ack_events");

    // Reset during beat 4 of a read, then re-request from scratch.
    do_reset();
    i_pull = 1'b1;
    i_tag  = 20'h00321;
    expect_ev(0, cmd_val(1'b0, 20'h00321));
    tick();
    i_pull  = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 4'(b);
      expect_ev(1, {20'h0, 4'(b)});
      tick();
    end
    mem_rvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 4'hA;
    @(negedge clk);
    chk("abort_busy", {23'h0, busy}, 24'h0);
    chk("abort_mem_req", {23'h0, mem_req}, 24'h0);
    tick();
    mem_rvalid = 1'b0;
    chk_empty("abort_events");
    i_pull = 1'b1;
    run_xfer(1'b0, 1, 20'h00321);
    i_pull = 1'b0;
    chk_empty("restart_events");

    // All requests held from reset: arbitration order.
    do_reset();
    d_push = 1'b1; d_pull = 1'b1; i_pull = 1'b1;
    d_tag  = 20'h00040;
    i_tag  = 20'h01234;
`ifdef LINE_XFER_RR_EN
    run_xfer(1'b1, 3, 20'h00040);
    run_xfer(1'b0, 1, 20'h01234);
    run_xfer(1'b1, 3, 20'h00040);
    run_xfer(1'b0, 1, 20'h01234);
`else
    for (int t = 0; t < 4; t++) run_xfer(1'b1, 3, 20'h00040);
`endif
    d_push = 1'b0;
    run_xfer(1'b0, 2, 20'h00040);
    d_pull = 1'b0; i_pull = 1'b0;
    tick();
    chk_empty("arb_events");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
